// File: rtl/rf_write_arbiter_pkg.sv
// Shared processor constants for the register-file write arbiter.
// Holds default widths, the PC-mirror register index and the PC limit
// under which a write to that register is flagged as clobbered.
package rf_write_arbiter_pkg;

    localparam int unsigned NUM_REQ_DEF = 3;    // 0=ALU, 1=memory load, 2=I/O input
    localparam int unsigned ADDR_W_DEF  = 5;    // 32 registers
    localparam int unsigned DATA_W_DEF  = 32;
    localparam int unsigned PC_W        = 10;
    localparam int unsigned CNT_W       = 16;
    localparam int unsigned R28_IDX     = 28;   // register mirrored from the PC
    localparam int unsigned PC_LIMIT    = 256;  // PC values below this keep R28 mirrored

    typedef enum logic [1:0] {
        REQ_ALU = 2'd0,
        REQ_MEM = 2'd1,
        REQ_IO  = 2'd2
    } req_id_e;

endpackage

// File: rtl/rf_write_skid.sv
// One-entry skid buffer for a single register-file write requester.
// Ports:
//   clock, reset       : clock and synchronous active-high reset
//   i_valid/o_ready    : handover handshake (capture when both high)
//   i_addr, i_data     : write payload captured on handover
//   i_pop              : arbiter grant, empties the entry at this edge
//   o_full, o_addr, o_data : current entry contents
module rf_write_skid
    import rf_write_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_valid,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    output logic              o_ready,
    output logic              o_full,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_data
);

    logic              r_valid;
    logic              r_ready;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic              w_take;

    assign w_take = i_valid & r_ready;

    // Ready is the registered inverse of the entry state, so it returns one
    // cycle after the entry empties and never depends on i_valid this cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_ready <= 1'b1;
            r_addr  <= '0;
            r_data  <= '0;
        end else begin
            if (w_take) begin
                r_valid <= 1'b1;
                r_addr  <= i_addr;
                r_data  <= i_data;
            end else if (i_pop) begin
                r_valid <= 1'b0;
            end
            r_ready <= ~r_valid & ~w_take;
        end
    end

    assign o_ready = r_ready;
    assign o_full  = r_valid;
    assign o_addr  = r_addr;
    assign o_data  = r_data;

endmodule

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter merging several register-file write requesters onto
// one write port, with a registered output stage, an R28/PC-mirror clobber
// flag and a saturating contention counter.
// Ports:
//   clock, reset                      : clock, synchronous active-high reset
//   req_valid/req_addr/req_data       : per-requester write handover (slice i)
//   req_ready                         : per-requester skid empty and accepting
//   hold                              : freezes grants while high
//   program_counter                   : current PC for the R28 check
//   writeAddress/writeData/writeRegister : register file write port
//   r28_clobber                       : pulse with a write to R28 while PC < 256
//   contention_count                  : saturating count of multi-pending cycles
module rf_write_arbiter
    import rf_write_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = NUM_REQ_DEF,
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      hold,
    input  logic [PC_W-1:0]           program_counter,
    output logic [ADDR_W-1:0]         writeAddress,
    output logic [DATA_W-1:0]         writeData,
    output logic                      writeRegister,
    output logic                      r28_clobber,
    output logic [CNT_W-1:0]          contention_count
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0] w_full;
    logic [NUM_REQ-1:0] w_pop;
    logic [ADDR_W-1:0]  w_skid_addr [NUM_REQ];
    logic [DATA_W-1:0]  w_skid_data [NUM_REQ];

    logic               w_gnt_vld;
    logic [PTR_W-1:0]   w_gnt_idx;
    logic [PTR_W-1:0]   w_next_ptr;
    logic [ADDR_W-1:0]  w_sel_addr;
    logic [DATA_W-1:0]  w_sel_data;
    logic               w_multi;
    logic               w_clobber;

    logic [PTR_W-1:0]   r_rr_ptr;
    logic               r_wr;
    logic [ADDR_W-1:0]  r_waddr;
    logic [DATA_W-1:0]  r_wdata;
    logic               r_clobber;
    logic [CNT_W-1:0]   r_cnt;

    // One skid entry per requester.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_skid
        rf_write_skid #(
            .ADDR_W (ADDR_W),
            .DATA_W (DATA_W)
        ) u_skid (
            .clock   (clock),
            .reset   (reset),
            .i_valid (req_valid[gi]),
            .i_addr  (req_addr[gi*ADDR_W +: ADDR_W]),
            .i_data  (req_data[gi*DATA_W +: DATA_W]),
            .i_pop   (w_pop[gi]),
            .o_ready (req_ready[gi]),
            .o_full  (w_full[gi]),
            .o_addr  (w_skid_addr[gi]),
            .o_data  (w_skid_data[gi])
        );
    end

    // Round-robin search upward from r_rr_ptr, wrapping at NUM_REQ.
    always_comb begin
        int unsigned idx;
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        w_pop     = '0;
        idx       = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = 32'(r_rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!hold && !w_gnt_vld && w_full[PTR_W'(idx)]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = PTR_W'(idx);
            end
        end
        w_pop[w_gnt_idx] = w_gnt_vld;
    end

    assign w_sel_addr = w_skid_addr[w_gnt_idx];
    assign w_sel_data = w_skid_data[w_gnt_idx];
    assign w_next_ptr = (w_gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + PTR_W'(1);
    assign w_clobber  = (w_sel_addr == ADDR_W'(R28_IDX)) &&
                        (program_counter < PC_W'(PC_LIMIT));

    // Two or more full entries, independent of hold.
    always_comb begin
        int unsigned nfull;
        nfull = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            nfull = nfull + 32'(w_full[k]);
        end
        w_multi = (nfull >= 2);
    end

    // Output stage, round-robin pointer and contention counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rr_ptr  <= '0;
            r_wr      <= 1'b0;
            r_waddr   <= '0;
            r_wdata   <= '0;
            r_clobber <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_wr      <= w_gnt_vld;
            r_clobber <= w_gnt_vld & w_clobber;
            if (w_gnt_vld) begin
                r_rr_ptr <= w_next_ptr;
                r_waddr  <= w_sel_addr;
                r_wdata  <= w_sel_data;
            end
            if (w_multi && (r_cnt != '1)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign writeRegister    = r_wr;
    assign writeAddress     = r_waddr;
    assign writeData        = r_wdata;
    assign r28_clobber      = r_clobber;
    assign contention_count = r_cnt;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model of the arbiter rules.
module tb_rf_write_arbiter;
    import rf_write_arbiter_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        hold  = 1'b0;
    logic [2:0]  req_valid = '0;
    logic [14:0] req_addr  = '0;
    logic [95:0] req_data  = '0;
    logic [9:0]  program_counter = '0;
    logic [2:0]  req_ready;
    logic [4:0]  writeAddress;
    logic [31:0] writeData;
    logic        writeRegister;
    logic        r28_clobber;
    logic [15:0] contention_count;

    int n_checks = 0;
    int n_fail   = 0;

    rf_write_arbiter dut (
        .clock            (clock),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_addr         (req_addr),
        .req_data         (req_data),
        .req_ready        (req_ready),
        .hold             (hold),
        .program_counter  (program_counter),
        .writeAddress     (writeAddress),
        .writeData        (writeData),
        .writeRegister    (writeRegister),
        .r28_clobber      (r28_clobber),
        .contention_count (contention_count)
    );

    always #5 clock = ~clock;

    // ---------------- behavioural model ----------------
    // A requester can hand over only when its entry has been empty for the
    // whole previous cycle; m_gcyc records the cycle its entry was last granted.
    bit          m_full [3];
    logic [4:0]  m_addr [3];
    logic [31:0] m_data [3];
    longint      m_gcyc [3];
    longint      m_cyc   = 0;
    int          m_rr    = 0;
    logic        m_wr    = 1'b0;
    logic [4:0]  m_waddr = '0;
    logic [31:0] m_wdata = '0;
    logic        m_clob  = 1'b0;
    int          m_cnt   = 0;

    function automatic logic [2:0] m_ready();
        logic [2:0] r;
        for (int i = 0; i < 3; i++) r[i] = !m_full[i] && (m_cyc >= m_gcyc[i] + 2);
        return r;
    endfunction

    always @(posedge clock) begin
        logic [2:0] rdy;
        int g;
        int nf;
        rdy = m_ready();
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                m_full[i] = 1'b0;
                m_gcyc[i] = m_cyc - 1;
            end
            m_rr = 0; m_wr = 1'b0; m_waddr = '0; m_wdata = '0; m_clob = 1'b0; m_cnt = 0;
        end else begin
            nf = 0;
            for (int i = 0; i < 3; i++) nf += int'(m_full[i]);
            if (nf >= 2 && m_cnt < 65535) m_cnt++;
            g = -1;
            if (!hold) begin
                for (int k = 0; k < 3; k++) begin
                    if (g < 0 && m_full[(m_rr + k) % 3]) g = (m_rr + k) % 3;
                end
            end
            m_wr   = (g >= 0);
            m_clob = 1'b0;
            if (g >= 0) begin
                m_waddr   = m_addr[g];
                m_wdata   = m_data[g];
                m_clob    = (m_addr[g] == 5'd28) && (program_counter < 10'd256);
                m_full[g] = 1'b0;
                m_gcyc[g] = m_cyc;
                m_rr      = (g + 1) % 3;
            end
            for (int i = 0; i < 3; i++) begin
                if (req_valid[i] && rdy[i]) begin
                    m_full[i] = 1'b1;
                    m_addr[i] = req_addr[i*5 +: 5];
                    m_data[i] = req_data[i*32 +: 32];
                end
            end
        end
        m_cyc++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        req_valid = '0;
        repeat (n) step();
    endtask

    task automatic drive(input int i, input logic [4:0] a, input logic [31:0] d);
        req_valid[i]          = 1'b1;
        req_addr[i*5 +: 5]    = a;
        req_data[i*32 +: 32]  = d;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1; hold = 1'b0; req_valid = '0;
        step(); step();
        reset = 1'b0;
        n_checks++;
        if (req_ready !== 3'b111) begin
            n_fail++; $display("FAIL reset_ready: got %b want 111", req_ready);
        end
        n_checks++;
        if ({writeRegister, r28_clobber} !== 2'b00) begin
            n_fail++; $display("FAIL reset_strobes: got wr=%b clob=%b want 0 0", writeRegister, r28_clobber);
        end
        n_checks++;
        if (writeAddress !== 5'd0 || writeData !== 32'd0) begin
            n_fail++; $display("FAIL reset_addr_data: got %0d/%h want 0/0", writeAddress, writeData);
        end
        n_checks++;
        if (contention_count !== 16'd0) begin
            n_fail++; $display("FAIL reset_count: got %0d want 0", contention_count);
        end
    endtask

    task automatic test_single_write();
        idle(3);
        drive(0, 5'd5, 32'h1234);
        step();
        req_valid = '0;
        n_checks++;
        if (req_ready[0] !== 1'b0 || writeRegister !== 1'b0) begin
            n_fail++; $display("FAIL single_c1: got ready0=%b wr=%b want 0 0", req_ready[0], writeRegister);
        end
        step();
        n_checks++;
        if ({req_ready[0], writeRegister, writeAddress, writeData} !== {1'b0, 1'b1, 5'd5, 32'h1234}) begin
            n_fail++; $display("FAIL single_c2: got ready0=%b wr=%b addr=%0d data=%h want 0 1 5 1234",
                               req_ready[0], writeRegister, writeAddress, writeData);
        end
        step();
        n_checks++;
        if ({req_ready[0], writeRegister, writeAddress} !== {1'b1, 1'b0, 5'd5}) begin
            n_fail++; $display("FAIL single_c3: got ready0=%b wr=%b addr=%0d want 1 0 5",
                               req_ready[0], writeRegister, writeAddress);
        end
    endtask

    task automatic test_three_way();
        logic [4:0] exp_a [3];
        exp_a[0] = 5'd1; exp_a[1] = 5'd2; exp_a[2] = 5'd3;
        reset = 1'b1; step(); reset = 1'b0;
        drive(0, 5'd1, 32'hA0); drive(1, 5'd2, 32'hA1); drive(2, 5'd3, 32'hA2);
        step();
        req_valid = '0;
        step();
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (writeRegister !== 1'b1 || writeAddress !== exp_a[k] || writeData !== 32'hA0 + 32'(k)) begin
                n_fail++; $display("FAIL three_way_order%0d: got wr=%b addr=%0d data=%h want 1 %0d %h",
                                   k, writeRegister, writeAddress, writeData, exp_a[k], 32'hA0 + 32'(k));
            end
            step();
        end
        n_checks++;
        if (writeRegister !== 1'b0 || contention_count !== 16'd2) begin
            n_fail++; $display("FAIL three_way_count: got wr=%b cnt=%0d want 0 2", writeRegister, contention_count);
        end
        // Pointer wrapped to 0: requester 0 beats requester 1.
        drive(1, 5'd9, 32'hB1); drive(0, 5'd8, 32'hB0);
        step();
        req_valid = '0;
        step();
        n_checks++;
        if (writeRegister !== 1'b1 || writeAddress !== 5'd8) begin
            n_fail++; $display("FAIL rr_wrap_first: got wr=%b addr=%0d want 1 8", writeRegister, writeAddress);
        end
        step();
        n_checks++;
        if (writeRegister !== 1'b1 || writeAddress !== 5'd9) begin
            n_fail++; $display("FAIL rr_wrap_second: got wr=%b addr=%0d want 1 9", writeRegister, writeAddress);
        end
    endtask

    task automatic test_hold();
        idle(4);
        hold = 1'b1;
        drive(1, 5'd7, 32'hCAFE);
        step();
        req_valid = '0;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (writeRegister !== 1'b0) begin
                n_fail++; $display("FAIL hold_blocked%0d: got wr=%b want 0", k, writeRegister);
            end
            step();
        end
        hold = 1'b0;
        n_checks++;
        if (writeRegister !== 1'b0) begin
            n_fail++; $display("FAIL hold_release_c0: got wr=%b want 0", writeRegister);
        end
        step();
        n_checks++;
        if ({writeRegister, writeAddress, writeData} !== {1'b1, 5'd7, 32'hCAFE}) begin
            n_fail++; $display("FAIL hold_release_c1: got wr=%b addr=%0d data=%h want 1 7 cafe",
                               writeRegister, writeAddress, writeData);
        end
    endtask

    task automatic test_r28();
        idle(4);
        program_counter = 10'd100;
        drive(2, 5'd28, 32'h28);
        step();
        req_valid = '0;
        step();
        n_checks++;
        if ({writeRegister, r28_clobber, writeAddress} !== {1'b1, 1'b1, 5'd28}) begin
            n_fail++; $display("FAIL r28_low_pc: got wr=%b clob=%b addr=%0d want 1 1 28",
                               writeRegister, r28_clobber, writeAddress);
        end
        step();
        n_checks++;
        if (r28_clobber !== 1'b0) begin
            n_fail++; $display("FAIL r28_pulse_len: got clob=%b want 0", r28_clobber);
        end
        idle(4);
        program_counter = 10'd300;
        drive(2, 5'd28, 32'h29);
        step();
        req_valid = '0;
        step();
        n_checks++;
        if ({writeRegister, r28_clobber, writeAddress} !== {1'b1, 1'b0, 5'd28}) begin
            n_fail++; $display("FAIL r28_high_pc: got wr=%b clob=%b addr=%0d want 1 0 28",
                               writeRegister, r28_clobber, writeAddress);
        end
    endtask

    task automatic test_reset_mid();
        idle(4);
        hold = 1'b1;
        drive(0, 5'd11, 32'hD0); drive(1, 5'd12, 32'hD1);
        step();
        req_valid = '0;
        step();
        reset = 1'b1; hold = 1'b0;
        step();
        reset = 1'b0;
        n_checks++;
        if ({writeRegister, req_ready, contention_count} !== {1'b0, 3'b111, 16'd0}) begin
            n_fail++; $display("FAIL mid_reset: got wr=%b ready=%b cnt=%0d want 0 111 0",
                               writeRegister, req_ready, contention_count);
        end
        for (int k = 0; k < 4; k++) begin
            step();
            n_checks++;
            if (writeRegister !== 1'b0) begin
                n_fail++; $display("FAIL mid_reset_stale%0d: got wr=%b addr=%0d want wr 0",
                                   k, writeRegister, writeAddress);
            end
        end
    endtask

    task automatic test_random();
        reset = 1'b1; step(); reset = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 299) == 0);
            hold  = ($urandom_range(0, 3) == 0);
            program_counter = 10'($urandom);
            req_valid = 3'($urandom);
            for (int i = 0; i < 3; i++) begin
                req_addr[i*5 +: 5]   = ($urandom_range(0, 3) == 0) ? 5'd28 : 5'($urandom);
                req_data[i*32 +: 32] = $urandom;
            end
            step();
            n_checks++;
            if (req_ready !== m_ready()) begin
                n_fail++; $display("FAIL rand_ready@%0d: got %b want %b", c, req_ready, m_ready());
            end
            n_checks++;
            if ({writeRegister, r28_clobber, writeAddress, writeData, contention_count} !==
                {m_wr, m_clob, m_waddr, m_wdata, 16'(m_cnt)}) begin
                n_fail++; $display("FAIL rand_out@%0d: got wr=%b clob=%b a=%0d d=%h cnt=%0d want %b %b %0d %h %0d",
                                   c, writeRegister, r28_clobber, writeAddress, writeData, contention_count,
                                   m_wr, m_clob, m_waddr, m_wdata, m_cnt);
            end
        end
        reset = 1'b0; hold = 1'b0; req_valid = '0;
    endtask

    task automatic test_saturation();
        reset = 1'b1; step(); reset = 1'b0;
        hold = 1'b1;
        drive(0, 5'd21, 32'hE0); drive(1, 5'd22, 32'hE1); drive(2, 5'd23, 32'hE2);
        step();
        req_valid = '0;
        n_checks++;
        if (contention_count !== 16'd0) begin
            n_fail++; $display("FAIL sat_start: got %0d want 0", contention_count);
        end
        repeat (65534) step();
        n_checks++;
        if (contention_count !== 16'hFFFE) begin
            n_fail++; $display("FAIL sat_below: got %0d want 65534", contention_count);
        end
        step();
        n_checks++;
        if (contention_count !== 16'hFFFF) begin
            n_fail++; $display("FAIL sat_reach: got %0d want 65535", contention_count);
        end
        repeat (4466) step();
        n_checks++;
        if (contention_count !== 16'hFFFF || writeRegister !== 1'b0) begin
            n_fail++; $display("FAIL sat_hold: got cnt=%0d wr=%b want 65535 0", contention_count, writeRegister);
        end
        hold = 1'b0;
        step();
        n_checks++;
        if ({writeRegister, writeAddress, writeData} !== {1'b1, 5'd21, 32'hE0}) begin
            n_fail++; $display("FAIL sat_drain: got wr=%b addr=%0d data=%h want 1 21 e0",
                               writeRegister, writeAddress, writeData);
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_three_way();
        test_hold();
        test_r28();
        test_reset_mid();
        test_random();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
